// File: rtl/barcode_seq_pkg.sv
// Shared definitions for the barcode LED driver sequencer: state encoding,
// PWM carrier width and the default CURREN settle time.
package barcode_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_GUARD  = 3'd2,
        ST_SEND   = 3'd3,
        ST_TAIL   = 3'd4
    } state_e;

    localparam int PWM_CNT_W             = 8;
    localparam int DEFAULT_SETTLE_CYCLES = 1200;

endpackage

// File: rtl/barcode_pwm_gen.sv
// PWM carrier for '1' symbols: an 8-bit counter cleared at each symbol start,
// compared against DUTY and registered so BARCODEPWM is glitch-free.
module barcode_pwm_gen
    import barcode_seq_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clear_i,
    input  logic                 send_i,
    input  logic                 bit_i,
    input  logic [PWM_CNT_W-1:0] duty_i,
    output logic                 pwm_o
);

    logic [PWM_CNT_W-1:0] cnt_q, cnt_d;
    logic                 pwm_q, pwm_d;

    // Inputs describe the coming cycle, so the compare uses the next count.
    always_comb begin
        cnt_d = clear_i ? '0 : cnt_q + PWM_CNT_W'(1);
        pwm_d = send_i & bit_i & (cnt_d < duty_i);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            pwm_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            pwm_q <= pwm_d;
        end
    end

    assign pwm_o = pwm_q;

endmodule

// File: rtl/barcode_pwm_seq.sv
// Sequencer driving CURREN/BARCODEEN/BARCODEPWM of the iCE40UP barcode LED
// driver: power-up settle, guard, LSB-first symbol serialisation, ordered shutdown.
module barcode_pwm_seq
    import barcode_seq_pkg::*;
#(
    parameter int DATA_W        = 32,
    parameter int LEN_W         = 6,
    parameter int DIV_W         = 16,
    parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START_VALID,
    output logic              START_READY,
    input  logic [DATA_W-1:0] PATTERN,
    input  logic [LEN_W-1:0]  PATTERN_LEN,
    input  logic [DIV_W-1:0]  BIT_DIV,
    input  logic [7:0]        DUTY,
    input  logic              ABORT,
    output logic              CURREN,
    output logic              BARCODEEN,
    output logic              BARCODEPWM,
    output logic              BUSY,
    output logic              DONE,
    output logic              ABORTED,
    output state_e            DBG_STATE
);

    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);

    state_e             state_q;
    logic [SET_W-1:0]   settle_cnt_q;
    logic [DIV_W-1:0]   div_cnt_q, div_q;
    logic [LEN_W-1:0]   idx_q, len_q;
    logic [DATA_W-1:0]  shift_q;
    logic [7:0]         duty_q;
    logic               curren_q, en_q, busy_q, done_q, aborted_q, abort_pend_q;

    logic [LEN_W-1:0]   len_clamped;
    logic               div_end, last_sym;
    logic               send_nx, clear_nx, bit_nx;

    assign len_clamped = (PATTERN_LEN > LEN_W'(DATA_W)) ? LEN_W'(DATA_W) : PATTERN_LEN;
    assign div_end     = (div_cnt_q == div_q);
    assign last_sym    = (idx_q == len_q - LEN_W'(1));

    // What the carrier sees in the coming cycle: SEND entry/continuation and symbol boundaries.
    always_comb begin
        send_nx  = 1'b0;
        clear_nx = 1'b0;
        bit_nx   = shift_q[0];
        case (state_q)
            ST_GUARD: begin
                if (!ABORT) begin
                    send_nx  = 1'b1;
                    clear_nx = 1'b1;
                end
            end
            ST_SEND: begin
                if (!ABORT && !(div_end && last_sym)) begin
                    send_nx = 1'b1;
                    if (div_end) begin
                        clear_nx = 1'b1;
                        bit_nx   = shift_q[1];
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            settle_cnt_q <= '0;
            div_cnt_q    <= '0;
            div_q        <= '0;
            idx_q        <= '0;
            len_q        <= '0;
            shift_q      <= '0;
            duty_q       <= '0;
            curren_q     <= 1'b0;
            en_q         <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
            abort_pend_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (START_VALID) begin
                        shift_q      <= PATTERN;
                        len_q        <= len_clamped;
                        div_q        <= BIT_DIV;
                        duty_q       <= DUTY;
                        aborted_q    <= 1'b0;
                        abort_pend_q <= 1'b0;
                        if (len_clamped == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q      <= ST_SETTLE;
                            settle_cnt_q <= SET_W'(1);
                            curren_q     <= 1'b1;
                            busy_q       <= 1'b1;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (ABORT) begin
                        state_q      <= ST_TAIL;
                        abort_pend_q <= 1'b1;
                    end else if (settle_cnt_q == SET_W'(SETTLE_CYCLES)) begin
                        state_q <= ST_GUARD;
                        en_q    <= 1'b1;
                    end else begin
                        settle_cnt_q <= settle_cnt_q + SET_W'(1);
                    end
                end
                ST_GUARD: begin
                    if (ABORT) begin
                        state_q      <= ST_TAIL;
                        en_q         <= 1'b0;
                        abort_pend_q <= 1'b1;
                    end else begin
                        state_q   <= ST_SEND;
                        div_cnt_q <= '0;
                        idx_q     <= '0;
                    end
                end
                ST_SEND: begin
                    if (ABORT) begin
                        state_q      <= ST_TAIL;
                        en_q         <= 1'b0;
                        abort_pend_q <= 1'b1;
                    end else if (div_end) begin
                        if (last_sym) begin
                            state_q <= ST_TAIL;
                            en_q    <= 1'b0;
                        end else begin
                            idx_q     <= idx_q + LEN_W'(1);
                            shift_q   <= shift_q >> 1;
                            div_cnt_q <= '0;
                        end
                    end else begin
                        div_cnt_q <= div_cnt_q + DIV_W'(1);
                    end
                end
                ST_TAIL: begin
                    // CURREN falls only here, one cycle after BARCODEEN.
                    state_q   <= ST_IDLE;
                    curren_q  <= 1'b0;
                    busy_q    <= 1'b0;
                    done_q    <= 1'b1;
                    aborted_q <= abort_pend_q;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    barcode_pwm_gen u_pwm (
        .clk_i   (CLK),
        .rst_i   (RST),
        .clear_i (clear_nx),
        .send_i  (send_nx),
        .bit_i   (bit_nx),
        .duty_i  (duty_q),
        .pwm_o   (BARCODEPWM)
    );

    assign START_READY = (state_q == ST_IDLE);
    assign CURREN      = curren_q;
    assign BARCODEEN   = en_q;
    assign BUSY        = busy_q;
    assign DONE        = done_q;
    assign ABORTED     = aborted_q;
    assign DBG_STATE   = state_q;

endmodule

// File: tb/tb_barcode_pwm_seq.sv
// Directed bench for barcode_pwm_seq with SETTLE_CYCLES=4; cycle 0 is the accept cycle.
module tb_barcode_pwm_seq;
  import barcode_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_valid = 1'b0;
  logic        start_ready;
  logic [31:0] pattern = '0;
  logic [5:0]  pattern_len = '0;
  logic [15:0] bit_div = '0;
  logic [7:0]  duty = '0;
  logic        abort = 1'b0;
  logic        curren, barcodeen, barcodepwm, busy, done, aborted;
  state_e      dbg_state;

  int errors = 0;
  int checks = 0;

  barcode_pwm_seq #(
    .DATA_W        (32),
    .LEN_W         (6),
    .DIV_W         (16),
    .SETTLE_CYCLES (4)
  ) dut (
    .CLK         (clk),
    .RST         (rst),
    .START_VALID (start_valid),
    .START_READY (start_ready),
    .PATTERN     (pattern),
    .PATTERN_LEN (pattern_len),
    .BIT_DIV     (bit_div),
    .DUTY        (duty),
    .ABORT       (abort),
    .CURREN      (curren),
    .BARCODEEN   (barcodeen),
    .BARCODEPWM  (barcodepwm),
    .BUSY        (busy),
    .DONE        (done),
    .ABORTED     (aborted),
    .DBG_STATE   (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a request, let the accept edge pass, and return in cycle 1.
  task automatic start(input logic [31:0] p, input logic [5:0] l, input logic [15:0] d, input logic [7:0] u);
    pattern     = p;
    pattern_len = l;
    bit_div     = d;
    duty        = u;
    start_valid = 1'b1;
    step();
    start_valid = 1'b0;
  endtask

  initial begin
    step();
    step();
    rst = 1'b0;
    step();
    check("rst ready", start_ready, 1);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst curren", curren, 0);
    check("rst en", barcodeen, 0);
    check("rst pwm", barcodepwm, 0);
    check("rst aborted", aborted, 0);

    // Pattern 101, three symbols of 4 cycles, full duty.
    start(32'b101, 6'd3, 16'd3, 8'd255);
    for (int c = 1; c <= 20; c++) begin
      check($sformatf("t1 cur c%0d", c), curren, (c >= 1 && c <= 18));
      check($sformatf("t1 en c%0d", c), barcodeen, (c >= 5 && c <= 17));
      check($sformatf("t1 pwm c%0d", c), barcodepwm, ((c >= 6 && c <= 9) || (c >= 14 && c <= 17)));
      check($sformatf("t1 done c%0d", c), done, (c == 19));
      check($sformatf("t1 busy c%0d", c), busy, (c >= 1 && c <= 18));
      step();
    end
    check("t1 aborted", aborted, 0);

    // Single '1' symbol of 8 cycles at DUTY=2, then DUTY=0.
    start(32'h1, 6'd1, 16'd7, 8'd2);
    for (int c = 1; c <= 15; c++) begin
      check($sformatf("t2a pwm c%0d", c), barcodepwm, (c == 6 || c == 7));
      check($sformatf("t2a en c%0d", c), barcodeen, (c >= 5 && c <= 13));
      check($sformatf("t2a done c%0d", c), done, (c == 15));
      step();
    end
    start(32'h1, 6'd1, 16'd7, 8'd0);
    for (int c = 1; c <= 15; c++) begin
      check($sformatf("t2b pwm c%0d", c), barcodepwm, 0);
      check($sformatf("t2b done c%0d", c), done, (c == 15));
      step();
    end

    // Abort during the second symbol.
    start(32'b101, 6'd3, 16'd3, 8'd255);
    for (int c = 1; c <= 13; c++) begin
      check($sformatf("t3 cur c%0d", c), curren, (c >= 1 && c <= 12));
      check($sformatf("t3 en c%0d", c), barcodeen, (c >= 5 && c <= 11));
      check($sformatf("t3 pwm c%0d", c), barcodepwm, (c >= 6 && c <= 9));
      check($sformatf("t3 done c%0d", c), done, (c == 13));
      check($sformatf("t3 aborted c%0d", c), aborted, (c == 13));
      if (c == 11) abort = 1'b1;
      if (c == 12) abort = 1'b0;
      step();
    end
    check("t3 aborted held", aborted, 1);

    // Zero-length pattern: DONE only, also clears ABORTED.
    start(32'hFF, 6'd0, 16'd3, 8'd255);
    check("t4 done c1", done, 1);
    check("t4 busy c1", busy, 0);
    check("t4 cur c1", curren, 0);
    check("t4 aborted c1", aborted, 0);
    check("t4 ready c1", start_ready, 1);
    step();
    check("t4 done c2", done, 0);
    check("t4 cur c2", curren, 0);

    // Back-to-back with START_VALID held; second pattern length 63 clamps to 32.
    pattern     = 32'h1;
    pattern_len = 6'd1;
    bit_div     = 16'd0;
    duty        = 8'd255;
    start_valid = 1'b1;
    step();
    pattern     = 32'hFFFF_FFFF;
    pattern_len = 6'd63;
    for (int c = 1; c <= 48; c++) begin
      if (c == 6) check("t5 pwm c6", barcodepwm, 1);
      if (c == 7) begin
        check("t5 tail cur", curren, 1);
        check("t5 tail en", barcodeen, 0);
      end
      if (c == 8) begin
        check("t5 done1", done, 1);
        check("t5 cur gap", curren, 0);
        check("t5 ready", start_ready, 1);
      end
      if (c == 9) begin
        check("t5 busy2", busy, 1);
        check("t5 cur2", curren, 1);
        start_valid = 1'b0;
      end
      if (c == 13) check("t5 guard en", barcodeen, 1);
      if (c == 13) check("t5 guard pwm", barcodepwm, 0);
      if (c == 45) begin
        check("t5 last en", barcodeen, 1);
        check("t5 last pwm", barcodepwm, 1);
      end
      if (c == 46) begin
        check("t5 tail2 en", barcodeen, 0);
        check("t5 tail2 cur", curren, 1);
        check("t5 tail2 done", done, 0);
      end
      if (c == 47) begin
        check("t5 done2", done, 1);
        check("t5 done2 cur", curren, 0);
      end
      if (c == 48) check("t5 idle busy", busy, 0);
      step();
    end

    // Asynchronous reset in the middle of SEND.
    start(32'b101, 6'd3, 16'd3, 8'd255);
    for (int c = 1; c < 7; c++) step();
    check("t6 pre pwm", barcodepwm, 1);
    check("t6 pre en", barcodeen, 1);
    rst = 1'b1;
    #1;
    check("t6 async cur", curren, 0);
    check("t6 async en", barcodeen, 0);
    check("t6 async pwm", barcodepwm, 0);
    step();
    rst = 1'b0;
    step();
    check("t6 ready", start_ready, 1);
    check("t6 done", done, 0);
    check("t6 busy", busy, 0);
    check("t6 cur", curren, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/barcode_pwm_seq.md
Name: barcode_pwm_seq

Overview:
Upstream sequencer for the iCE40UP barcode LED driver hard-IP wrapper. It drives that wrapper's CURREN, BARCODEEN and BARCODEPWM inputs.
- Accepts a barcode symbol pattern over a valid/ready handshake.
- Powers up the current reference and waits a settle time.
- Enables the driver and serialises the pattern LSB-first: '1' symbols are PWM-modulated at a programmable duty, '0' symbols are dark.
- Shuts the driver down in a defined order.

Parameters:
DATA_W, 32, maximum symbols per pattern
LEN_W, 6, width of PATTERN_LEN (must hold DATA_W)
DIV_W, 16, width of BIT_DIV
SETTLE_CYCLES, 1200, CURREN-to-BARCODEEN settle time in CLK cycles (100 us at 12 MHz); must be >=1

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous, active-high reset
START_VALID  in  1  pattern request
START_READY  out  1  sequencer can accept a request
PATTERN  in  DATA_W  symbol bits, bit 0 sent first
PATTERN_LEN  in  LEN_W  number of symbols to send
BIT_DIV  in  DIV_W  symbol period minus one, in cycles
DUTY  in  8  PWM high count per 256-cycle carrier for '1' symbols
ABORT  in  1  terminate the current sequence
CURREN  out  1  to driver CURREN
BARCODEEN  out  1  to driver BARCODEEN
BARCODEPWM  out  1  to driver BARCODEPWM
BUSY  out  1  high in any state other than IDLE
DONE  out  1  one-cycle pulse on return to IDLE
ABORTED  out  1  last sequence was aborted; cleared on next accept

Behaviour:
- Clocking and reset: single clock CLK; reset RST is asynchronous, active-high.
- Reset values: CURREN=0, BARCODEEN=0, BARCODEPWM=0, BUSY=0, DONE=0, ABORTED=0, state=IDLE.
- START_READY = (state==IDLE), so it reads 1 after reset. All other outputs are registered.
- Accept: START_VALID & START_READY at cycle 0 latches PATTERN, BIT_DIV, DUTY and min(PATTERN_LEN, DATA_W), and clears ABORTED.
- PATTERN_LEN==0: no driver activity; DONE=1 at cycle 1; remain in IDLE.
- States and transitions:
  - IDLE: all driver outputs 0.
  - SETTLE: CURREN=1 for SETTLE_CYCLES cycles (cycles 1..S).
  - GUARD: one cycle at S+1; BARCODEEN=1, BARCODEPWM=0.
  - SEND: L symbols of D+1 cycles each (D = BIT_DIV). Symbol k occupies cycles S+2+k(D+1) .. S+1+(k+1)(D+1). CURREN=BARCODEEN=1 throughout.
  - TAIL: one cycle at E+1, where E = S+1+L(D+1). BARCODEEN=0, BARCODEPWM=0, CURREN=1.
  - IDLE at E+2: CURREN=0, DONE=1 for one cycle.
- PWM carrier:
  - 8-bit counter cleared at the start of every symbol, wraps 255->0.
  - For a '1' symbol, BARCODEPWM = (cnt < DUTY). A '0' symbol drives 0.
  - DUTY=0 gives always 0; DUTY=255 gives high 255 of every 256 cycles.
  - D+1 < 256 truncates the carrier.
- Power ordering is invariant:
  - BARCODEEN=1 implies CURREN=1.
  - BARCODEPWM=1 implies BARCODEEN=1.
  - CURREN never falls in the same cycle BARCODEEN falls.
- ABORT:
  - In SETTLE, GUARD or SEND, the next cycle forces BARCODEPWM=0 and BARCODEEN=0 and enters TAIL. The cycle after returns to IDLE with DONE=1 and ABORTED=1.
  - In TAIL, ABORT is ignored.
  - In IDLE, ABORT has no effect; a simultaneous START_VALID is accepted.
- Inputs are ignored while BUSY. Back-to-back: with START_VALID held, the next accept happens in the DONE cycle.
- RST mid-operation: all driver outputs drop to 0 immediately (asynchronously). No DONE pulse is generated.
- Counters: settle counter ceil(log2(SETTLE_CYCLES+1)) bits, symbol-period counter DIV_W bits, symbol index LEN_W bits. No counter overflows for legal parameters.

Decomposition:
- Shared package/header barcode_seq_pkg:
  - state encoding (IDLE, SETTLE, GUARD, SEND, TAIL);
  - PWM_CNT_W=8;
  - default SETTLE_CYCLES constant.
- One sub-module, barcode_pwm_gen: 8-bit carrier counter with synchronous clear, and the DUTY compare gated by the symbol bit and the SEND state.
- The FSM, settle counter, period counter and shift register live in the top.

Test Plan:
1. SETTLE_CYCLES=4, PATTERN=0b101, LEN=3, BIT_DIV=3, DUTY=255, accept at cycle 0 -> CURREN 1..18; BARCODEEN 5..17; BARCODEPWM high 6-9 and 14-17, low 10-13; TAIL 18; DONE at 19.
2. PATTERN=1, LEN=1, BIT_DIV=7, DUTY=2 -> PWM high the first 2 of 8 symbol cycles. Repeat with DUTY=0 -> PWM never high.
3. Case 1 with ABORT at cycle 11 -> BARCODEEN/PWM 0 from cycle 12, CURREN low at 13, DONE and ABORTED at 13.
4. PATTERN_LEN=0 accepted -> CURREN never rises, DONE at cycle 1, BUSY stays 0.
5. START_VALID held with two patterns -> second accepted exactly in the first DONE cycle; CURREN low at least one cycle between sequences. PATTERN_LEN=63 is clamped to 32 symbols.
6. RST asserted mid-SEND -> CURREN, BARCODEEN and BARCODEPWM go 0 asynchronously; after release START_READY=1, DONE=0.
